// File: rtl/router_in_port_if.sv
// Handshake bundle between an upstream neighbour, the router input port and the arbiter.
// slave = the input port itself; master = the environment driving it.
interface router_in_port_if #(
  parameter int pckg_sz = 40
);
  logic [pckg_sz-1:0] data_out_i_in;
  logic               pndng_i_in;
  logic               popin;
  logic [pckg_sz-1:0] data_out_i;
  logic               pndng_i;
  logic               pop_i;
  logic [1:0]         trn;

  modport master (
    output data_out_i_in, pndng_i_in, pop_i, trn,
    input  popin, data_out_i, pndng_i
  );

  modport slave (
    input  data_out_i_in, pndng_i_in, pop_i, trn,
    output popin, data_out_i, pndng_i
  );
endinterface

// File: rtl/router_in_port.sv
// Mesh router input port: accepts 1 packet / 2 cycles into a FIFO, head is routed with 0-cycle decode;
// a full FIFO holds the upstream packet pending. Optional pkt_cnt via ROUTER_IN_PORT_STATS_EN.
module router_in_port #(
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4,
  parameter int id         = 0,
  parameter int id_r       = 1,
  parameter int id_c       = 1,
  parameter int rows       = 4,
  parameter int columns    = 4
) (
  input logic              clk,
  input logic              rst,
  router_in_port_if.slave  bus
`ifdef ROUTER_IN_PORT_STATS_EN
  ,
  output logic [15:0]      pkt_cnt
`endif
);

  localparam int PW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(fifo_depth);
  localparam logic [3:0]  OWN_R    = 4'(id_r);
  localparam logic [3:0]  OWN_C    = 4'(id_c);
  localparam logic [1:0]  OWN_ID   = 2'(id);

  // Target fields are 4 bits wide, so the mesh cannot exceed 15x15.
  if (fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0 ||
      rows > 15 || columns > 15 || id < 0 || id > 3) begin : g_bad_cfg
    $error("router_in_port: unsupported parameter set");
  end

  typedef enum logic {IDLE, ACK} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_popin, w_popin_nxt;
  logic               w_wr, w_rd;
  logic [pckg_sz-1:0] r_mem [fifo_depth];
  logic [PW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [PW:0]        r_count;
  logic [pckg_sz-1:0] w_head, w_dout;
  logic [3:0]         w_tr, w_tc;
  logic               w_mode;
  logic [1:0]         w_port;

  // Full is judged on the registered count; a same-cycle pop does not free a slot.
  always_comb begin
    w_state_nxt = r_state;
    w_popin_nxt = 1'b0;
    w_wr        = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.pndng_i_in && (r_count != FULL_CNT)) begin
          w_wr        = 1'b1;
          w_popin_nxt = 1'b1;
          w_state_nxt = ACK;
        end
      end
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_popin <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_popin <= w_popin_nxt;
    end
  end

  assign bus.popin = r_popin;
  assign w_rd      = bus.pop_i && (bus.trn == OWN_ID) && (r_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= bus.data_out_i_in;
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign bus.pndng_i = (r_count != '0);

  always_comb begin
    w_tr   = w_head[pckg_sz-9 -: 4];
    w_tc   = w_head[pckg_sz-13 -: 4];
    w_mode = w_head[pckg_sz-17];
    w_port = OWN_ID;
    if (w_mode) begin
      if      (w_tr < OWN_R) w_port = 2'd0;
      else if (w_tr > OWN_R) w_port = 2'd2;
      else if (w_tc > OWN_C) w_port = 2'd1;
      else if (w_tc < OWN_C) w_port = 2'd3;
    end else begin
      if      (w_tc > OWN_C) w_port = 2'd1;
      else if (w_tc < OWN_C) w_port = 2'd3;
      else if (w_tr < OWN_R) w_port = 2'd0;
      else if (w_tr > OWN_R) w_port = 2'd2;
    end
    w_dout = w_head;
    w_dout[pckg_sz-1 -: 8] = {6'b0, w_port};
    if (r_count == '0) w_dout = '0;
  end

  assign bus.data_out_i = w_dout;

`ifdef ROUTER_IN_PORT_STATS_EN
  logic [15:0] r_pkt_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_pkt_cnt <= '0;
    else if (w_wr && r_pkt_cnt != 16'hFFFF) r_pkt_cnt <= r_pkt_cnt + 16'd1;
  end

  assign pkt_cnt = r_pkt_cnt;
`endif

endmodule

// File: tb/tb_router_in_port.sv
// Bench for router_in_port (id=0 at row 2, col 2): directed scenarios then random traffic vs a queue model.
module tb_router_in_port;
  localparam int W   = 40;
  localparam int D   = 4;
  localparam int ID  = 0;
  localparam int IDR = 2;
  localparam int IDC = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  router_in_port_if #(.pckg_sz(W)) bus ();

`ifdef ROUTER_IN_PORT_STATS_EN
  logic [15:0] pkt_cnt;
`endif

  router_in_port #(
    .pckg_sz(W), .fifo_depth(D), .id(ID), .id_r(IDR), .id_c(IDC), .rows(4), .columns(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ROUTER_IN_PORT_STATS_EN
    ,
    .pkt_cnt(pkt_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q[$];
  bit           m_ack;
  int           m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Route from signed offsets to the target: primary axis first, then the other, else own port.
  function automatic logic [1:0] route(input logic [W-1:0] p);
    int dr, dc, vert, horz, first, second;
    dr   = int'(p[W-9 -: 4]) - IDR;
    dc   = int'(p[W-13 -: 4]) - IDC;
    vert = (dr < 0) ? 0 : (dr > 0) ? 2 : -1;
    horz = (dc > 0) ? 1 : (dc < 0) ? 3 : -1;
    first  = p[W-17] ? vert : horz;
    second = p[W-17] ? horz : vert;
    if (first >= 0)  return 2'(first);
    if (second >= 0) return 2'(second);
    return 2'(ID);
  endfunction

  function automatic logic [W-1:0] expect_out();
    logic [W-1:0] r;
    if (q.size() == 0) return '0;
    r = q[0];
    r[W-1 -: 8] = {6'b0, route(q[0])};
    return r;
  endfunction

  function automatic logic [W-1:0] make_pkt(input int tr, input int tc, input int mode);
    logic [63:0]  r;
    logic [W-1:0] p;
    r = {$urandom, $urandom};
    p = r[W-1:0];
    p[W-9 -: 4]  = 4'(tr);
    p[W-13 -: 4] = 4'(tc);
    p[W-17]      = mode[0];
    return p;
  endfunction

  // One clock: predict from current inputs, take the edge, compare at the following negedge.
  task automatic step(input string tag);
    bit           acc, rd;
    logic [W-1:0] data;
    acc  = !m_ack && bus.pndng_i_in && (q.size() < D);
    rd   = bus.pop_i && (bus.trn == 2'(ID)) && (q.size() != 0);
    data = bus.data_out_i_in;
    @(posedge clk);
    if (rd) void'(q.pop_front());
    if (acc) begin
      q.push_back(data);
      if (m_cnt < 65535) m_cnt++;
    end
    m_ack = acc;
    @(negedge clk);
    check({tag, ".popin"},   64'(bus.popin),      64'(m_ack));
    check({tag, ".pndng_i"}, 64'(bus.pndng_i),    64'(q.size() != 0));
    check({tag, ".data"},    64'(bus.data_out_i), 64'(expect_out()));
`ifdef ROUTER_IN_PORT_STATS_EN
    check({tag, ".pkt_cnt"}, 64'(pkt_cnt), 64'(m_cnt));
`endif
  endtask

  task automatic reset_dut(input string tag);
    rst = 1'b1;
    #1;
    check({tag, ".rst_popin"}, 64'(bus.popin),      64'd0);
    check({tag, ".rst_pndng"}, 64'(bus.pndng_i),    64'd0);
    check({tag, ".rst_data"},  64'(bus.data_out_i), 64'd0);
    q.delete();
    m_ack = 1'b0;
    m_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
`ifdef ROUTER_IN_PORT_STATS_EN
    #1;
    check({tag, ".rst_pkt_cnt"}, 64'(pkt_cnt), 64'd0);
`endif
  endtask

  initial begin
    int pulses;
    int last_pulse;
    bus.data_out_i_in = '0;
    bus.pndng_i_in    = 1'b0;
    bus.pop_i         = 1'b0;
    bus.trn           = 2'd0;
    #1;
    reset_dut("init");

    // Single packet routed north, row-first.
    bus.data_out_i_in = make_pkt(0, 3, 1);
    bus.pndng_i_in    = 1'b1;
    step("r034a");
    check("r034.popin_pulse", 64'(bus.popin), 64'd1);
    bus.pndng_i_in = 1'b0;
    step("r034b");
    check("r034.pndng_i", 64'(bus.pndng_i), 64'd1);
    check("r034.hdr", 64'(bus.data_out_i[39:32]), 64'h00);

    reset_dut("r035a");
    bus.data_out_i_in = make_pkt(2, 5, 1);
    bus.pndng_i_in    = 1'b1;
    step("r035a1");
    bus.pndng_i_in = 1'b0;
    step("r035a2");
    check("r035.east", 64'(bus.data_out_i[39:32]), 64'h01);

    reset_dut("r035b");
    bus.data_out_i_in = make_pkt(4, 0, 0);
    bus.pndng_i_in    = 1'b1;
    step("r035b1");
    bus.pndng_i_in = 1'b0;
    step("r035b2");
    check("r035.west", 64'(bus.data_out_i[39:32]), 64'h03);

    reset_dut("illegal");
    bus.data_out_i_in = make_pkt(2, 2, 0);
    bus.pndng_i_in    = 1'b1;
    step("illegal1");
    check("illegal.own_port", 64'(bus.data_out_i[39:32]), 64'(ID));

    // Continuous upstream, no pops: fills the FIFO at one packet per two cycles.
    reset_dut("r036");
    bus.data_out_i_in = make_pkt(3, 1, 1);
    bus.pndng_i_in    = 1'b1;
    pulses     = 0;
    last_pulse = -2;
    for (int i = 0; i < 14; i++) begin
      step("r036");
      if (bus.popin) begin
        check("r036.gap", 64'(i - last_pulse), 64'd2);
        last_pulse = i;
        pulses++;
      end
    end
    check("r036.pulses", 64'(pulses), 64'd4);
    check("r036.pndng_i", 64'(bus.pndng_i), 64'd1);

    // Full FIFO: pop on another port's turn is ignored; a real pop frees a slot for the next cycle.
    bus.pop_i = 1'b1;
    bus.trn   = 2'd1;
    step("r037_wrong_trn");
    check("r037.no_accept_wrong_trn", 64'(bus.popin), 64'd0);
    bus.trn = 2'd0;
    step("r037_pop");
    check("r037.no_accept_same_cycle", 64'(bus.popin), 64'd0);
    bus.pop_i = 1'b0;
    step("r037_refill");
    check("r037.accept_next", 64'(bus.popin), 64'd1);

    // Reset while in the acknowledge cycle with two packets stored.
    reset_dut("r038pre");
    bus.data_out_i_in = make_pkt(1, 1, 0);
    bus.pndng_i_in    = 1'b1;
    step("r038a");
    step("r038b");
    step("r038c");
    check("r038.in_ack", 64'(bus.popin), 64'd1);
    bus.pndng_i_in = 1'b0;
    reset_dut("r038");
    step("r038_post");
    check("r038.no_stale_popin", 64'(bus.popin), 64'd0);
    bus.pndng_i_in = 1'b1;
    step("r031_first");
    check("r031.first_accept", 64'(bus.popin), 64'd1);

    // Random traffic; upstream presents a new packet only after its current one is acknowledged.
    bus.pndng_i_in = 1'b0;
    reset_dut("rand");
    for (int i = 0; i < 600; i++) begin
      if (!bus.pndng_i_in || bus.popin) begin
        bus.pndng_i_in    = ($urandom_range(0, 3) != 0);
        bus.data_out_i_in = make_pkt($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
      end
      bus.pop_i = ($urandom_range(0, 2) == 0);
      bus.trn   = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'(ID);
      if ($urandom_range(0, 149) == 0) reset_dut("rand_rst");
      else                             step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
